color_vote_filter: RTL and testbench
====================================

Name: color_vote_filter

Overview:
- Downstream consumer of the colour-detection stage.
- Watches the detector's filter[1:0] and color[1:0] outputs and samples color once per completed detection frame.
- Majority-votes over a window of frames and publishes a debounced colour with valid/changed strobes to the bot's decision logic.
- Flags a stale condition when the upstream stage stops producing frames.

Parameters:
- WINDOW, 5, frames per vote window; legal range 1..15.
- THRESH, 3, minimum votes for a colour to win; legal range WINDOW/2 < THRESH <= WINDOW.
- TIMEOUT, 4000, clk_1MHz cycles without a frame before stale asserts; legal range 2..65535.

Ports:
- clk_1MHz  input  1  system clock, 1 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- filter  input  2  detector filter select; 2 = clear/evaluate phase.
- color  input  2  detector result: 0 none, 1 red, 2 green, 3 blue.
- stable_color  output  2  voted colour, same encoding as color.
- vote_valid  output  1  one-cycle pulse when a window decision registers.
- color_changed  output  1  one-cycle pulse when stable_color takes a new value.
- stale  output  1  high while upstream frames are missing.
- votes_in_window  output  4  number of frames counted in the current window.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs 0, all counters 0, FSM in COLLECT.
  - Reset mid-window discards all partial votes.
- Frame detect:
  - f2_q is a register holding (filter==2).
  - frame_tick = f2_q && (filter!=2), i.e. the first cycle after the evaluate phase ends.
  - color is sampled on the frame_tick cycle.
- Vote counters:
  - Four counters cnt0..cnt3, 4 bits each, index = sampled colour.
  - On frame_tick: cnt[color] += 1 and votes_in_window += 1.
  - Counters never exceed WINDOW, so there is no wrap.
- FSM states: COLLECT, DECIDE.
  - COLLECT -> DECIDE on the edge at which votes_in_window reaches WINDOW.
  - DECIDE lasts exactly one cycle, then returns to COLLECT with all counters and votes_in_window cleared.
- Decision, in DECIDE:
  - winner = lowest index i in 1..3 with cnt[i] >= THRESH; if none, winner = 0.
  - On the edge leaving DECIDE: stable_color <= winner, vote_valid = 1 for one cycle.
  - If winner != previous stable_color, color_changed = 1 in the same cycle.
- Latency: vote_valid asserts 2 clk_1MHz edges after the edge that samples the WINDOW-th frame.
- frame_tick during DECIDE: clear counters and load the new sample as vote 1 of the new window; the sample is never lost.
- Timeout:
  - 16-bit idle counter clears on frame_tick and otherwise increments, saturating at TIMEOUT.
  - When it reaches TIMEOUT:
    - stale <= 1;
    - partial window discarded;
    - stable_color <= 0;
    - color_changed pulses if stable_color was nonzero;
    - vote_valid stays 0.
  - stale clears on the next frame_tick, and that frame counts as vote 1.
- Simultaneous timeout and frame_tick: frame_tick wins; stale does not assert.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: COLOR_VOTE_HYST_EN.
- Enabled:
  - A winner different from stable_color is held as a candidate.
  - stable_color updates only when two consecutive windows produce the same candidate.
  - vote_valid still pulses every window; color_changed pulses only on an actual update.
  - Timeout clears the candidate.
- Disabled: every window decision updates stable_color immediately, as described above.

Test Plan:
- Reset, then 5 frames with color=1 -> on the 5th window edge +2: stable_color=1, vote_valid and color_changed pulse once; votes_in_window returns to 0.
- Frame colours 2,2,3,2,0 (WINDOW=5, THRESH=3) -> stable_color=2; a following window of 3,3,1,2,0 gives no colour with >= 3 votes -> stable_color=0, color_changed pulses.
- Hold filter=3 for 4000 cycles after 2 frames of red -> stale=1, stable_color=0, no vote_valid; the next frame_tick clears stale and votes_in_window=1.
- Assert rst_n=0 after 3 frames, then release and send 5 blue frames -> the first vote_valid arrives only after all 5 new frames, with stable_color=3.
- With COLOR_VOTE_HYST_EN: stable red, then one green window -> vote_valid pulses, stable_color stays 1; a second green window -> stable_color=2 with color_changed.
- Filter sequence 3,0,1,2,3 with a 1-cycle filter=2 phase -> exactly one frame_tick per frame; filter held at 2 for multiple cycles still yields one tick.

Source files
------------

// File: rtl/color_vote_filter.sv
// color_vote_filter: majority-vote debounce of the colour detector output with stale-frame detection.
// Optional candidate hysteresis is enabled by defining COLOR_VOTE_HYST_EN.
module color_vote_filter #(
   parameter int WINDOW  = 5,
   parameter int THRESH  = 3,
   parameter int TIMEOUT = 4000
) (
   input  logic       clk_1MHz,
   input  logic       rst_n,
   input  logic [1:0] filter,
   input  logic [1:0] color,
   output logic [1:0] stable_color,
   output logic       vote_valid,
   output logic       color_changed,
   output logic       stale,
   output logic [3:0] votes_in_window
);
   typedef enum logic {COLLECT, DECIDE} state_t;
   state_t      state, state_nxt;
   logic        f2_q, frame_tick, timeout, take;
   logic [3:0]  cnt [4];
   logic [15:0] idle;
   logic [1:0]  winner;

   // A frame completes on the first cycle after the evaluate phase (filter==2) ends.
   assign frame_tick = f2_q && (filter != 2'd2);
   // Fires once, on the edge the idle counter would reach TIMEOUT; a frame on that edge wins.
   assign timeout = !frame_tick && (idle == 16'(TIMEOUT - 1));

   // Lowest colour index with enough votes wins; no qualifying colour means "none".
   always_comb begin
      winner = (cnt[1] >= 4'(THRESH)) ? 2'd1 :
               (cnt[2] >= 4'(THRESH)) ? 2'd2 :
               (cnt[3] >= 4'(THRESH)) ? 2'd3 : 2'd0;
   end

   // Decide for one cycle once the window is full; a timeout abandons the window.
   always_comb begin
      state_nxt = (timeout || state == DECIDE) ? COLLECT :
                  (votes_in_window == 4'(WINDOW)) ? DECIDE : COLLECT;
   end

   // FSM state register.
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   // Evaluate-phase history used for frame edge detection.
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) f2_q <= 1'b0;
      else        f2_q <= (filter == 2'd2);
   end

`ifdef COLOR_VOTE_HYST_EN
   logic [1:0] cand;
   logic       cand_v;

   // A differing winner must repeat in the next window before it is accepted.
   assign take = (winner != stable_color) && cand_v && (cand == winner);

   // Candidate register: set by a new differing winner, dropped on acceptance, agreement or timeout.
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         cand   <= 2'd0;
         cand_v <= 1'b0;
      end else if (timeout) begin
         cand   <= 2'd0;
         cand_v <= 1'b0;
      end else if (state == DECIDE) begin
         cand   <= winner;
         cand_v <= (winner != stable_color) && !take;
      end
   end
`else
   assign take = (winner != stable_color);
`endif

   // Vote counting, window decision, idle timeout and registered outputs.
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         cnt             <= '{default: '0};
         votes_in_window <= 4'd0;
         idle            <= 16'd0;
         stable_color    <= 2'd0;
         vote_valid      <= 1'b0;
         color_changed   <= 1'b0;
         stale           <= 1'b0;
      end else begin
         vote_valid    <= 1'b0;
         color_changed <= 1'b0;
         idle          <= frame_tick ? 16'd0 : (idle == 16'(TIMEOUT)) ? idle : idle + 16'd1;
         if (timeout) begin
            stale           <= 1'b1;
            stable_color    <= 2'd0;
            color_changed   <= (stable_color != 2'd0);
            cnt             <= '{default: '0};
            votes_in_window <= 4'd0;
         end else begin
            if (state == DECIDE) begin
               vote_valid      <= 1'b1;
               cnt             <= '{default: '0};
               votes_in_window <= 4'd0;
               if (take) begin
                  stable_color  <= winner;
                  color_changed <= 1'b1;
               end
            end
            if (frame_tick) begin
               stale           <= 1'b0;
               cnt[color]      <= (state == DECIDE) ? 4'd1 : cnt[color] + 4'd1;
               votes_in_window <= (state == DECIDE) ? 4'd1 : votes_in_window + 4'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_color_vote_filter.sv
// tb_color_vote_filter: scoreboard bench for color_vote_filter; expectations follow COLOR_VOTE_HYST_EN when defined.
module tb_color_vote_filter;
`ifdef COLOR_VOTE_HYST_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   typedef struct packed {
      int         cyc;
      logic [1:0] sc;
      logic       vv;
      logic       cc;
      logic       st;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] filter, color, stable_color, votes_unused;
   logic       vote_valid, color_changed, stale, stale_prev = 1'b0;
   logic [3:0] votes;
   int         cyc = 0, checks = 0, errors = 0, last_sample = 0;
   exp_t       q [$];
   exp_t       me;

   color_vote_filter dut (
      .clk_1MHz(clk), .rst_n(rst_n), .filter(filter), .color(color),
      .stable_color(stable_color), .vote_valid(vote_valid), .color_changed(color_changed),
      .stale(stale), .votes_in_window(votes)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every output event is matched in order against the scoreboard, including its cycle.
   always @(negedge clk) begin
      if (rst_n && (vote_valid || color_changed || stale != stale_prev)) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d sc=%0d vv=%0b cc=%0b st=%0b, required no event",
                     cyc, stable_color, vote_valid, color_changed, stale);
         end else begin
            me = q.pop_front();
            if (cyc != me.cyc || stable_color != me.sc || vote_valid != me.vv ||
                color_changed != me.cc || stale != me.st) begin
               errors++;
               $display("FAIL event got cyc=%0d sc=%0d vv=%0b cc=%0b st=%0b, required cyc=%0d sc=%0d vv=%0b cc=%0b st=%0b",
                        cyc, stable_color, vote_valid, color_changed, stale, me.cyc, me.sc, me.vv, me.cc, me.st);
            end
         end
      end
      stale_prev = stale;
   end

   function automatic exp_t mk(input int off, input logic [1:0] sc, input logic vv, input logic cc, input logic st);
      mk = '{cyc: off, sc: sc, vv: vv, cc: cc, st: st};
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, act, req);
      end
   endtask

   // One detector frame: pre cycles of other filters (3,0,1,...), hold cycles of filter=2, then the tick cycle.
   task automatic frame(input logic [1:0] c, input int pre, input int hold, input logic [1:0] tf,
                        input bit ev, input exp_t e);
      for (int i = 0; i < pre; i++) begin
         filter = (i % 3 == 0) ? 2'd3 : (i % 3 == 1) ? 2'd0 : 2'd1;
         @(posedge clk); #1;
      end
      for (int i = 0; i < hold; i++) begin
         filter = 2'd2;
         @(posedge clk); #1;
      end
      filter = tf;
      color = c;
      last_sample = cyc + 1;
      if (ev) begin
         e.cyc = e.cyc + last_sample;
         q.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   // Five frames; colours listed first-to-last in cs, expectation attached to the last one.
   task automatic win(input logic [9:0] cs, input exp_t e);
      for (int i = 0; i < 5; i++) begin
         frame(cs[9-2*i -: 2], 2, 2, 2'd0, i == 4, e);
         if (i == 3) chk("votes_before_last", votes, 4);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("votes_cleared", votes, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      filter = 2'd0;
      color = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stable", stable_color, 0);
      chk("rst_vote_valid", vote_valid, 0);
      chk("rst_changed", color_changed, 0);
      chk("rst_stale", stale, 0);
      chk("rst_votes", votes, 0);
      rst_n = 1'b1;

      win({2'd1, 2'd1, 2'd1, 2'd1, 2'd1}, mk(2, HYST ? 2'd0 : 2'd1, 1, !HYST, 0));
      if (HYST) win({2'd1, 2'd1, 2'd1, 2'd1, 2'd1}, mk(2, 2'd1, 1, 1, 0));
      win({2'd2, 2'd2, 2'd3, 2'd2, 2'd0}, mk(2, HYST ? 2'd1 : 2'd2, 1, !HYST, 0));
      win({2'd3, 2'd3, 2'd1, 2'd2, 2'd0}, mk(2, HYST ? 2'd1 : 2'd0, 1, !HYST, 0));
      if (HYST) begin
         win({2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, mk(2, 2'd1, 1, 0, 0));
         win({2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, mk(2, 2'd2, 1, 1, 0));
      end
      win({2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, mk(2, HYST ? 2'd2 : 2'd3, 1, !HYST, 0));

      frame(2'd1, 2, 2, 2'd0, 0, mk(0, 0, 0, 0, 0));
      frame(2'd1, 2, 2, 2'd0, 0, mk(0, 0, 0, 0, 0));
      chk("votes_two_red", votes, 2);
      q.push_back(mk(last_sample + 4000, 2'd0, 0, 1, 1));
      filter = 2'd3;
      repeat (4010) @(posedge clk);
      #1;
      chk("stale_set", stale, 1);
      chk("stale_stable", stable_color, 0);
      chk("stale_votes_discarded", votes, 0);
      frame(2'd1, 0, 2, 2'd0, 1, mk(0, 2'd0, 0, 0, 0));
      chk("stale_cleared", stale, 0);
      chk("votes_after_stale", votes, 1);

      frame(2'd1, 2, 2, 2'd0, 0, mk(0, 0, 0, 0, 0));
      frame(2'd1, 2, 2, 2'd0, 0, mk(0, 0, 0, 0, 0));
      chk("votes_before_reset", votes, 3);
      rst_n = 1'b0;
      #1;
      chk("votes_in_reset", votes, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      win({2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, mk(2, HYST ? 2'd0 : 2'd3, 1, !HYST, 0));

      frame(2'd2, 3, 1, 2'd3, 0, mk(0, 0, 0, 0, 0));
      chk("votes_short_eval", votes, 1);
      frame(2'd2, 0, 4, 2'd0, 0, mk(0, 0, 0, 0, 0));
      chk("votes_long_eval", votes, 2);
      frame(2'd2, 2, 2, 2'd0, 0, mk(0, 0, 0, 0, 0));
      frame(2'd2, 2, 2, 2'd0, 0, mk(0, 0, 0, 0, 0));
      frame(2'd2, 0, 1, 2'd0, 1, mk(2, HYST ? 2'd0 : 2'd2, 1, !HYST, 0));
      frame(2'd2, 0, 1, 2'd0, 0, mk(0, 0, 0, 0, 0));
      chk("votes_tick_in_decide", votes, 1);

      repeat (10) @(posedge clk);
      #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
